// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one block-transfer memory between the I-cache and D-cache.
// Optional performance counters are enabled with MEM_ARB_PERF_EN.
module cache_mem_arbiter #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3,
    localparam int BW                = DATA_WIDTH << BLOCK_OFFSET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [BW-1:0]         wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [BW-1:0]         wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [BW-1:0]         rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BW-1:0]         mem_block_din,
    input  logic                  mem_block_valid,
    input  logic [BW-1:0]         mem_block_dout
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           grant_cnt0,
    output logic [31:0]           grant_cnt1,
    output logic [31:0]           conflict_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   rr_q, rr_d;

    logic                  gnt_req;
    logic                  gnt_we;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [BW-1:0]         gnt_wdata;

    always_comb begin
        if (grant_q) begin
            gnt_req   = req1;
            gnt_we    = we1;
            gnt_addr  = addr1;
            gnt_wdata = wdata1;
        end else begin
            gnt_req   = req0;
            gnt_we    = we0;
            gnt_addr  = addr0;
            gnt_wdata = wdata0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        ack0          = 1'b0;
        ack1          = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_block_din = '0;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    grant_d = (req0 && req1) ? rr_q : req1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                mem_en        = 1'b1;
                mem_we        = gnt_we;
                mem_addr      = {gnt_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH],
                                 {BLOCK_OFFSET_WIDTH{1'b0}}};
                mem_block_din = gnt_wdata;
                // A requester that withdraws mid-transfer is dropped without an ack.
                if (!gnt_req) begin
                    state_d = StGap;
                end else if (mem_block_valid) begin
                    ack0    = ~grant_q;
                    ack1    = grant_q;
                    rr_d    = ~grant_q;
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rdata = mem_block_dout;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (ack0) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (ack1) grant_cnt1 <= grant_cnt1 + 32'd1;
            if (state_q == StIdle && req0 && req1) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
